// File: rtl/v_pkg.sv
// Shared definitions for the vector sequencer: unit select encoding, FSM states,
// functional-unit count and the one-hot unit decode.
package v_pkg;

    localparam int FU_NUM = 5;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_MUL  = 3'd1,
        FU_SLDU = 3'd2,
        FU_RED  = 3'd3,
        FU_LSU  = 3'd4,
        FU_CFG  = 3'd5
    } fu_sel_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } seq_state_e;

    function automatic logic [FU_NUM-1:0] fu_onehot(input logic [2:0] sel);
        return FU_NUM'(1) << sel;
    endfunction

endpackage

// File: rtl/v_seq_wdog.sv
// Watchdog down-counter for the WAIT state: reloaded on load, counts while run,
// flags expired on the cycle the count sits at zero.
module v_seq_wdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load,
    output logic expired
);

    localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 16'd1;
        end
    end

    // Loaded with N-1 so the Nth WAIT cycle is the one that sees zero.
    assign expired = run && (cnt == '0);

endmodule

// File: rtl/v_seq_ctrl.sv
// Vector instruction sequencer: issues to one functional unit, waits for its done,
// then strobes writeback. Optional WAIT watchdog under macro V_SEQ_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | ready, accepting an instruction
// S_ISSUE | one-cycle start pulse to the latched unit
// S_WAIT  | waiting for the latched unit's done
// S_WB    | one-cycle writeback / config strobe
module v_seq_ctrl
    import v_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        fu_sel,
    input  logic              v_wr_req,
    input  logic              x_wr_req,
    input  logic [4:0]        vd_in,
    input  logic [FU_NUM-1:0] fu_done,
    output logic [FU_NUM-1:0] fu_start,
    output logic              v_wb_en,
    output logic              x_wb_en,
    output logic              cfg_wr_en,
    output logic [4:0]        vd_out,
    output logic              busy,
    output logic              ill_instr,
    output logic              err_timeout,
    input  logic              err_clr
);

    seq_state_e state, state_nxt;
    logic [2:0] fu_q;
    logic       v_q;
    logic       x_q;
    logic [4:0] vd_q;
    logic       ill_q;
    logic       accept;
    logic       done_sel;
    logic       expired;
    logic       tmo_hit;

    assign accept   = instr_valid && (state == S_IDLE);
    assign done_sel = |(fu_done & fu_onehot(fu_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            fu_q  <= '0;
            v_q   <= 1'b0;
            x_q   <= 1'b0;
            vd_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ill_q <= accept && (fu_sel > FU_CFG);
            if (accept) begin
                fu_q <= fu_sel;
                v_q  <= v_wr_req;
                x_q  <= x_wr_req;
                vd_q <= vd_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fu_start  = '0;
        v_wb_en   = 1'b0;
        x_wb_en   = 1'b0;
        cfg_wr_en = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fu_sel == FU_CFG) begin
                        state_nxt = S_WB;
                    end else if (fu_sel < FU_CFG) begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                fu_start  = fu_onehot(fu_q);
                state_nxt = done_sel ? S_WB : S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle still completes normally.
                if (done_sel) begin
                    state_nxt = S_WB;
                end else if (expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                cfg_wr_en = (fu_q == FU_CFG);
                v_wb_en   = v_q && (fu_q != FU_CFG);
                x_wb_en   = x_q && (fu_q != FU_CFG);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign vd_out      = vd_q;
    assign ill_instr   = ill_q;

`ifdef V_SEQ_TIMEOUT_EN
    logic wdog_run;
    logic wdog_load;
    logic err_q;

    assign wdog_run  = (state == S_WAIT);
    assign wdog_load = (state == S_ISSUE);

    v_seq_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .run     (wdog_run),
        .load    (wdog_load),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_tmo;

    assign expired     = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_tmo  = err_clr ^ tmo_hit ^ (^16'(TIMEOUT_CYC));
`endif

endmodule

// File: tb/tb_v_seq_ctrl.sv
// Scoreboard bench for v_seq_ctrl: each cycle's expected outputs are queued as the
// stimulus is driven and compared at the following falling edge.
module tb_v_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] fu_sel;
    logic       v_wr_req;
    logic       x_wr_req;
    logic [4:0] vd_in;
    logic [4:0] fu_done;
    logic [4:0] fu_start;
    logic       v_wb_en;
    logic       x_wb_en;
    logic       cfg_wr_en;
    logic [4:0] vd_out;
    logic       busy;
    logic       ill_instr;
    logic       err_timeout;
    logic       err_clr;

    always #5 clk = ~clk;

    v_seq_ctrl #(
        .TIMEOUT_CYC(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fu_sel      (fu_sel),
        .v_wr_req    (v_wr_req),
        .x_wr_req    (x_wr_req),
        .vd_in       (vd_in),
        .fu_done     (fu_done),
        .fu_start    (fu_start),
        .v_wb_en     (v_wb_en),
        .x_wb_en     (x_wb_en),
        .cfg_wr_en   (cfg_wr_en),
        .vd_out      (vd_out),
        .busy        (busy),
        .ill_instr   (ill_instr),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    typedef struct packed {
        logic       ready;
        logic       bsy;
        logic [4:0] start;
        logic       vwb;
        logic       xwb;
        logic       cfg;
        logic       ill;
        logic       err;
        logic [4:0] vd;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
        logic  vd_care;
    } sb_t;

    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    sb_t  sb_cur;
    obs_t obs_act;
    logic err_st;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic obs_t e_idle(input logic err);
        return '{ready: 1'b1, bsy: 1'b0, start: 5'd0, vwb: 1'b0, xwb: 1'b0,
                 cfg: 1'b0, ill: 1'b0, err: err, vd: 5'd0};
    endfunction

    function automatic obs_t e_ill(input logic err);
        obs_t o = e_idle(err);
        o.ill = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_busy(input logic [4:0] start, input logic vwb, input logic xwb,
                                    input logic cfg, input logic err, input logic [4:0] vd);
        return '{ready: 1'b0, bsy: 1'b1, start: start, vwb: vwb, xwb: xwb,
                 cfg: cfg, ill: 1'b0, err: err, vd: vd};
    endfunction

    // Enter the next cycle and queue what the DUT must show during it.
    task automatic exp_cyc(input string tag, input obs_t e, input logic vd_care);
        @(posedge clk);
        #1;
        sb_q.push_back('{tag: tag, exp: e, vd_care: vd_care});
    endtask

    task automatic send(input logic [2:0] fu, input logic v, input logic x, input logic [4:0] vd);
        instr_valid = 1'b1;
        fu_sel      = fu;
        v_wr_req    = v;
        x_wr_req    = x;
        vd_in       = vd;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_cur  = sb_q.pop_front();
            obs_act = {instr_ready, busy, fu_start, v_wb_en, x_wb_en, cfg_wr_en,
                       ill_instr, err_timeout, vd_out};
            if (!sb_cur.vd_care) obs_act.vd = sb_cur.exp.vd;
            chk(sb_cur.tag, 32'(obs_act), 32'(sb_cur.exp));
        end
    end

    initial begin
`ifdef V_SEQ_TIMEOUT_EN
        err_st = 1'b1;
`else
        err_st = 1'b0;
`endif
        rst = 1'b1;
        instr_valid = 1'b0;
        fu_sel = 3'd0;
        v_wr_req = 1'b0;
        x_wr_req = 1'b0;
        vd_in = 5'd0;
        fu_done = 5'd0;
        err_clr = 1'b0;
        @(posedge clk);
        exp_cyc("reset", e_idle(1'b0), 1'b1);
        rst = 1'b0;

        // ALU, done in WAIT at T+3
        exp_cyc("alu_t0", e_idle(1'b0), 1'b0);         send(3'd0, 1'b1, 1'b0, 5'd7);
        exp_cyc("alu_t1", e_busy(5'b00001, 0, 0, 0, 0, 5'd7), 1'b1); instr_valid = 1'b0;
        exp_cyc("alu_t2", e_busy(5'b0, 0, 0, 0, 0, 5'd7), 1'b1);
        exp_cyc("alu_t3", e_busy(5'b0, 0, 0, 0, 0, 5'd7), 1'b1);      fu_done = 5'b00001;
        exp_cyc("alu_t4", e_busy(5'b0, 1, 0, 0, 0, 5'd7), 1'b1);      fu_done = 5'b0;
        exp_cyc("alu_t5", e_idle(1'b0), 1'b0);

        // MUL, minimum latency: done during ISSUE
        send(3'd1, 1'b1, 1'b1, 5'd9);
        exp_cyc("mul_t1", e_busy(5'b00010, 0, 0, 0, 0, 5'd9), 1'b1);  instr_valid = 1'b0; fu_done = 5'b00010;
        exp_cyc("mul_t2", e_busy(5'b0, 1, 1, 0, 0, 5'd9), 1'b1);      fu_done = 5'b0;
        exp_cyc("mul_t3", e_idle(1'b0), 1'b0);

        // CFG
        send(3'd5, 1'b1, 1'b1, 5'd3);
        exp_cyc("cfg_t1", e_busy(5'b0, 0, 0, 1, 0, 5'd3), 1'b1);      instr_valid = 1'b0;
        exp_cyc("cfg_t2", e_idle(1'b0), 1'b0);

        // RED, scalar writeback only
        send(3'd3, 1'b0, 1'b1, 5'd12);
        exp_cyc("red_t1", e_busy(5'b01000, 0, 0, 0, 0, 5'd12), 1'b1); instr_valid = 1'b0; fu_done = 5'b01000;
        exp_cyc("red_t2", e_busy(5'b0, 0, 1, 0, 0, 5'd12), 1'b1);     fu_done = 5'b0;
        exp_cyc("red_t3", e_idle(1'b0), 1'b0);

        // Illegal 6 then 7 back to back; stray dones ignored
        send(3'd6, 1'b1, 1'b1, 5'd4);
        exp_cyc("ill6_t1", e_ill(1'b0), 1'b0);                         send(3'd7, 1'b1, 1'b0, 5'd5); fu_done = 5'b11111;
        exp_cyc("ill7_t1", e_ill(1'b0), 1'b0);                         instr_valid = 1'b0;
        exp_cyc("ill_t3", e_idle(1'b0), 1'b0);                         fu_done = 5'b0;
        exp_cyc("ill_t4", e_idle(1'b0), 1'b0);

        // SLDU: other units' done ignored in ISSUE and WAIT
        send(3'd2, 1'b1, 1'b0, 5'd21);
        exp_cyc("sldu_t1", e_busy(5'b00100, 0, 0, 0, 0, 5'd21), 1'b1); instr_valid = 1'b0; fu_done = 5'b11011;
        exp_cyc("sldu_t2", e_busy(5'b0, 0, 0, 0, 0, 5'd21), 1'b1);     fu_done = 5'b00001;
        exp_cyc("sldu_t3", e_busy(5'b0, 0, 0, 0, 0, 5'd21), 1'b1);     fu_done = 5'b00100;
        exp_cyc("sldu_t4", e_busy(5'b0, 1, 0, 0, 0, 5'd21), 1'b1);     fu_done = 5'b0;
        exp_cyc("sldu_t5", e_idle(1'b0), 1'b0);

        // Valid held while busy: second instruction taken on the first IDLE cycle
        send(3'd5, 1'b0, 1'b0, 5'd1);
        exp_cyc("hold_t1", e_busy(5'b0, 0, 0, 1, 0, 5'd1), 1'b1);      vd_in = 5'd2;
        exp_cyc("hold_t2", e_idle(1'b0), 1'b0);
        exp_cyc("hold_t3", e_busy(5'b0, 0, 0, 1, 0, 5'd2), 1'b1);      instr_valid = 1'b0;
        exp_cyc("hold_t4", e_idle(1'b0), 1'b0);

        // No done: watchdog fires after 4 WAIT cycles, or waits forever without it
        send(3'd0, 1'b1, 1'b1, 5'd10);
        exp_cyc("tmo_t1", e_busy(5'b00001, 0, 0, 0, 0, 5'd10), 1'b1);  instr_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_cyc($sformatf("tmo_wait%0d", i), e_busy(5'b0, 0, 0, 0, 0, 5'd10), 1'b1);
`ifdef V_SEQ_TIMEOUT_EN
        exp_cyc("tmo_set", e_idle(1'b1), 1'b0);                        err_clr = 1'b1;
        exp_cyc("tmo_clr", e_idle(1'b0), 1'b0);                        err_clr = 1'b0;
        // Reloaded on re-entry; expiry with err_clr held still sets the flag
        send(3'd1, 1'b0, 1'b0, 5'd11);
        exp_cyc("tmo2_t1", e_busy(5'b00010, 0, 0, 0, 0, 5'd11), 1'b1); instr_valid = 1'b0; err_clr = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_cyc($sformatf("tmo2_wait%0d", i), e_busy(5'b0, 0, 0, 0, 0, 5'd11), 1'b1);
        exp_cyc("tmo2_setwin", e_idle(1'b1), 1'b0);                    err_clr = 1'b0;
        exp_cyc("tmo2_sticky", e_idle(1'b1), 1'b0);
`else
        err_clr = 1'b1;
        for (int i = 4; i < 10; i++)
            exp_cyc($sformatf("tmo_wait%0d", i), e_busy(5'b0, 0, 0, 0, 0, 5'd10), 1'b1);
        err_clr = 1'b0;
        fu_done = 5'b00001;
        exp_cyc("tmo_wb", e_busy(5'b0, 1, 1, 0, 0, 5'd10), 1'b1);      fu_done = 5'b0;
        exp_cyc("tmo_idle", e_idle(1'b0), 1'b0);
`endif

        // Reset in WAIT: back to reset values, late done produces no writeback
        send(3'd4, 1'b1, 1'b0, 5'd17);
        exp_cyc("rstw_t1", e_busy(5'b10000, 0, 0, 0, err_st, 5'd17), 1'b1); instr_valid = 1'b0;
        exp_cyc("rstw_t2", e_busy(5'b0, 0, 0, 0, err_st, 5'd17), 1'b1);     rst = 1'b1;
        exp_cyc("rstw_t3", e_idle(1'b0), 1'b1);                        rst = 1'b0; fu_done = 5'b10000;
        exp_cyc("rstw_t4", e_idle(1'b0), 1'b1);                        fu_done = 5'b0;
        exp_cyc("rstw_t5", e_idle(1'b0), 1'b1);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/v_seq_ctrl.md
V_SEQ_CTRL -- requirements
Module: v_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of WAIT cycles before abort (range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port instr_valid, input, 1 bit: a decoded vector instruction is presented.
REQ-005 SHALL have port instr_ready, output, 1 bit: the sequencer can accept an instruction; high only in IDLE.
REQ-006 SHALL have port fu_sel, input, 3 bits: target unit, encoded 0 ALU, 1 MUL, 2 SLDU, 3 RED, 4 LSU, 5 CFG; 6 and 7 are illegal.
REQ-007 SHALL have ports v_wr_req and x_wr_req, inputs, 1 bit each: the instruction writes the vector or scalar regfile.
REQ-008 SHALL have port vd_in, input, 5 bits: destination register.
REQ-009 SHALL have port fu_done, input, 5 bits: per-unit done, bit index equal to fu_sel.
REQ-010 SHALL have port fu_start, output, 5 bits: one-hot, one-cycle start pulse to the selected unit.
REQ-011 SHALL have ports v_wb_en, x_wb_en and cfg_wr_en, outputs, 1 bit each: one-cycle writeback strobes.
REQ-012 SHALL have port vd_out, output, 5 bits: the latched destination, valid while busy.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port ill_instr, output, 1 bit: one-cycle pulse on acceptance of an illegal fu_sel.
REQ-015 SHALL have port err_timeout, output, 1 bit: sticky watchdog error flag.
REQ-016 SHALL have port err_clr, input, 1 bit: clears err_timeout.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and WB.
REQ-018 SHALL accept an instruction only when instr_valid and instr_ready are both high, in cycle T, latching fu_sel, v_wr_req, x_wr_req and vd_in.
REQ-019 SHALL, for a legal fu_sel 0..4, go from IDLE to ISSUE and assert fu_start[fu_sel] for exactly cycle T+1.
REQ-020 SHALL, in ISSUE or WAIT, sample fu_done only at the latched unit's bit; done on any other bit SHALL be ignored.
REQ-021 SHALL go ISSUE->WB if done is seen in ISSUE, ISSUE->WAIT otherwise, and WAIT->WB when done is seen.
REQ-022 SHALL, in WB (one cycle), pulse v_wb_en equal to the latched v_wr_req and x_wb_en equal to the latched x_wr_req; WB->IDLE follows.
REQ-023 SHALL give a minimum latency of done at T+1, writeback at T+2, and instr_ready high at T+3.
REQ-024 SHALL, for fu_sel 5 (CFG), go IDLE->WB with no fu_start, pulse cfg_wr_en at T+1 with v_wb_en and x_wb_en low, and be ready at T+2.
REQ-025 SHALL, for fu_sel 6 or 7, accept the instruction, pulse ill_instr at T+1, stay in IDLE, and issue no start and no writeback.
REQ-026 SHALL ignore instr_valid while busy; an instruction held valid SHALL be accepted on the first IDLE cycle.
REQ-027 SHALL never assert more than one bit of fu_start, and never assert fu_start and a writeback strobe in the same cycle.

Reset
REQ-028 SHALL, on rst high at a clock edge, from any state including mid-operation, enter IDLE.
REQ-029 SHALL, after reset, hold fu_start=0, all wb strobes=0, ill_instr=0, err_timeout=0, vd_out=0, busy=0 and instr_ready=1.
REQ-030 SHALL generate no writeback for an instruction aborted by reset.

Configuration
REQ-031 SHALL, with macro V_SEQ_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYC it SHALL set err_timeout, go to IDLE with no writeback, and reload the counter on every entry to WAIT.
REQ-032 SHALL, with V_SEQ_TIMEOUT_EN defined, clear err_timeout on err_clr; if a timeout and err_clr occur in the same cycle, the set SHALL win.
REQ-033 SHALL, without V_SEQ_TIMEOUT_EN, include no counter, tie err_timeout to 0, ignore err_clr, and wait in WAIT indefinitely.

Structure
REQ-034 SHALL take the fu_sel enumeration, the FSM state enumeration and the FU count constant (5) from v_pkg.
REQ-035 SHALL place the watchdog counter in sub-module v_seq_wdog (inputs clk, rst, run, load; output expired), instantiated only under V_SEQ_TIMEOUT_EN.

Verification
REQ-036 SHALL cover: ALU instr (fu_sel=0, v_wr_req=1, vd_in=7) at T, done at T+3 -> fu_start=5'b00001 at T+1, v_wb_en at T+4, vd_out=7, ready at T+5.
REQ-037 SHALL cover: CFG instr -> no fu_start, cfg_wr_en at T+1, ready at T+2; RED with x_wr_req=1 -> x_wb_en only.
REQ-038 SHALL cover: fu_sel=6 -> ill_instr pulse at T+1, no start, ready at T+1.
REQ-039 SHALL cover: SLDU issued, fu_done[0] pulsed in WAIT -> ignored; fu_done[2] then -> WB.
REQ-040 SHALL cover: TIMEOUT_CYC=4 with V_SEQ_TIMEOUT_EN, no done -> err_timeout after 4 WAIT cycles, no writeback, err_clr clears it; rst asserted in WAIT -> IDLE, all outputs at reset values.
